// File: rtl/a2d_pkg.sv
// Shared types and command encoding for the A2D scan controller.
package a2d_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_CMD,
        S_WAIT1,
        S_RD,
        S_WAIT2,
        S_CAPT,
        S_GAP
    } scan_state_t;

    localparam logic [15:0] A2D_CMD_BASE = 16'h0000;
    localparam int          A2D_ADDR_LSB = 11;

    // Conversion command word: channel address sits in bits [13:11].
    function automatic logic [15:0] a2d_cmd(input logic [2:0] addr);
        return A2D_CMD_BASE | (16'(addr) << A2D_ADDR_LSB);
    endfunction

endpackage

// File: rtl/SPI_mstr16.sv
// 16-bit SPI master, mode 0, SCLK = clk/16, SS_n framed around one word.
module SPI_mstr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    logic        act_q, act_d;
    logic [3:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shft_q, shft_d;
    logic        smp_q, smp_d;
    logic        done_q, done_d;
    logic        ss_q, ss_d;

    // MISO sampled just before SCLK rises, word shifted as SCLK falls.
    always_comb begin
        act_d  = act_q;
        div_d  = div_q;
        bit_d  = bit_q;
        shft_d = shft_q;
        smp_d  = smp_q;
        ss_d   = ss_q;
        done_d = 1'b0;
        if (!act_q) begin
            if (wrt) begin
                act_d  = 1'b1;
                ss_d   = 1'b0;
                div_d  = 4'd0;
                bit_d  = 4'd0;
                shft_d = cmd;
            end
        end else begin
            div_d = div_q + 4'd1;
            if (div_q == 4'd7) smp_d = MISO;
            if (div_q == 4'd15) begin
                shft_d = {shft_q[14:0], smp_q};
                bit_d  = bit_q + 4'd1;
                if (bit_q == 4'd15) begin
                    act_d  = 1'b0;
                    ss_d   = 1'b1;
                    done_d = 1'b1;
                end
            end
        end
    end

    // Shift engine state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= 1'b0;
            div_q  <= 4'd0;
            bit_q  <= 4'd0;
            shft_q <= 16'h0000;
            smp_q  <= 1'b0;
            ss_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            shft_q <= shft_d;
            smp_q  <= smp_d;
            ss_q   <= ss_d;
            done_q <= done_d;
        end
    end

    assign SCLK    = act_q & div_q[3];
    assign MOSI    = shft_q[15];
    assign SS_n    = ss_q;
    assign done    = done_q;
    assign rd_data = shft_q;

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Multi-channel A2D scan controller: sweeps enabled slots, two SPI words each.
module a2d_scan_ctrl
    import a2d_pkg::*;
#(
    parameter int                    NUM_CH  = 3,
    parameter int                    DATA_W  = 12,
    parameter logic [3*NUM_CH-1:0]   CH_ADDR = {3'd5, 3'd4, 3'd0},
    parameter int                    GAP_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cont_en,
    input  logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH*DATA_W-1:0] smpl,
    output logic [NUM_CH-1:0]        vld,
    output logic                     sweep_done,
    output logic                     busy,
    output logic                     SS_n,
    output logic                     SCLK,
    output logic                     MOSI,
    input  logic                     MISO
);

    localparam int SW = $clog2(NUM_CH + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    scan_state_t              state_q, state_d;
    logic [SW-1:0]            slot_q, slot_d;
    logic [NUM_CH-1:0]        en_q, en_d;
    logic [GW-1:0]            gap_q, gap_d;
    logic [NUM_CH*DATA_W-1:0] smpl_q, smpl_d;
    logic [NUM_CH-1:0]        vld_q, vld_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;

    logic [SW-1:0] idx;
    logic [2:0]    addr;
    logic [15:0]   cmd;
    logic [15:0]   rd_data;
    logic          wrt;
    logic          spi_done;
    logic          sel_end;
    logic          unused_rd;

    // Slot is only out of range in SEL at sweep end; clamp so indexing stays legal.
    assign idx  = (slot_q < SW'(NUM_CH)) ? slot_q : '0;
    assign addr = CH_ADDR[3*idx +: 3];
    assign cmd  = a2d_cmd(addr);
    assign wrt  = (state_q == S_CMD) || (state_q == S_RD);
    // Sweep ends as soon as no enabled slot remains, so trailing disabled
    // slots (or an empty mask) cost no extra cycles.
    assign sel_end   = ((en_q >> slot_q) == '0);
    assign unused_rd = ^rd_data;

    SPI_mstr16 u_spi (
        .clk     (clk),
        .rst_n   (~rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .done    (spi_done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    // Next-state and registered-output logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        en_d    = en_q;
        gap_d   = gap_q;
        smpl_d  = smpl_q;
        busy_d  = busy_q;
        vld_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start || cont_en) begin
                en_d    = ch_en;
                slot_d  = '0;
                busy_d  = 1'b1;
                state_d = S_SEL;
            end
            S_SEL: begin
                if (sel_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    gap_d   = '0;
                    state_d = cont_en ? S_GAP : S_IDLE;
                end else if (!en_q[idx]) begin
                    slot_d = slot_q + SW'(1);
                end else begin
                    state_d = S_CMD;
                end
            end
            S_CMD:   state_d = S_WAIT1;
            S_WAIT1: if (spi_done) state_d = S_RD;
            S_RD:    state_d = S_WAIT2;
            S_WAIT2: if (spi_done) state_d = S_CAPT;
            S_CAPT: begin
                smpl_d[idx*DATA_W +: DATA_W] = rd_data[DATA_W-1:0];
                vld_d[idx] = 1'b1;
                slot_d     = slot_q + SW'(1);
                state_d    = S_SEL;
            end
            S_GAP: begin
                if (!cont_en) begin
                    state_d = S_IDLE;
                end else if (gap_q == GW'(GAP_CYC - 1)) begin
                    en_d    = ch_en;
                    slot_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_SEL;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            en_q    <= '0;
            gap_q   <= '0;
            smpl_q  <= '0;
            vld_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            en_q    <= en_d;
            gap_q   <= gap_d;
            smpl_q  <= smpl_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign smpl       = smpl_q;
    assign vld        = vld_q;
    assign sweep_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl with a behavioural A2D SPI slave.
module tb_a2d_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cont_en;
    logic [2:0]  ch_en;
    logic [35:0] smpl;
    logic [2:0]  vld;
    logic        sweep_done;
    logic        busy;
    logic        SS_n, SCLK, MOSI, MISO;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    a2d_scan_ctrl #(
        .NUM_CH  (3),
        .DATA_W  (12),
        .CH_ADDR (9'b101_100_000),
        .GAP_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cont_en    (cont_en),
        .ch_en      (ch_en),
        .smpl       (smpl),
        .vld        (vld),
        .sweep_done (sweep_done),
        .busy       (busy),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO)
    );

    // A2D slave: answers each frame with the conversion of the channel
    // addressed by the previous frame; upper bits are junk on purpose.
    function automatic logic [15:0] a2d_val(input logic [2:0] ch);
        case (ch)
            3'd0:    return 16'hBA5C;
            3'd4:    return 16'h73C1;
            3'd5:    return 16'h1FFF;
            default: return 16'h0123;
        endcase
    endfunction

    logic [15:0] s_sh = 16'h0;
    logic [15:0] s_rx = 16'h0;
    logic [2:0]  prev_ch = 3'd0;
    logic [15:0] fq[$];
    logic [2:0]  vq[$];
    int          done_cnt = 0;
    int          ss_low = 0;

    assign MISO = s_sh[15];

    always @(negedge SS_n or posedge SCLK) begin
        if (SCLK) begin
            s_rx = {s_rx[14:0], MOSI};
            s_sh = s_sh << 1;
        end else begin
            s_sh = a2d_val(prev_ch);
            s_rx = 16'h0;
        end
    end

    always @(posedge SS_n) begin
        fq.push_back(s_rx);
        prev_ch = s_rx[13:11];
    end

    always @(negedge clk) begin
        if (sweep_done === 1'b1) done_cnt++;
        if (|vld) vq.push_back(vld);
        if (SS_n === 1'b0) ss_low++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (sweep_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int fb, vb, db, sb, cnt;
    bit ok;
    logic [15:0] exp_cmd [6];

    initial begin
        exp_cmd = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};
        rst = 1'b1; start = 1'b0; cont_en = 1'b0; ch_en = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_smpl", 64'(smpl), 64'd0);
        chk("rst_vld", 64'(vld), 64'd0);
        chk("rst_done", 64'(sweep_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ss", 64'(SS_n), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // full sweep; ch_en change and extra start mid-sweep must be ignored
        fb = fq.size(); vb = vq.size(); db = done_cnt;
        ch_en = 3'b111;
        pulse_start();
        chk("t1_busy", 64'(busy), 64'd1);
        ch_en = 3'b000;
        @(negedge clk);
        chk("t1_ss_cmd", 64'(SS_n), 64'd1);
        @(negedge clk);
        chk("t1_ss_low", 64'(SS_n), 64'd0);
        repeat (100) @(negedge clk);
        pulse_start();
        wait_done(3000, "t1_to");
        @(negedge clk);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_frames", 64'(fq.size() - fb), 64'd6);
        if (fq.size() >= fb + 6)
            for (int i = 0; i < 6; i++) chk("t1_cmd", 64'(fq[fb+i]), 64'(exp_cmd[i]));
        chk("t1_nvld", 64'(vq.size() - vb), 64'd3);
        if (vq.size() >= vb + 3) begin
            chk("t1_vld0", 64'(vq[vb]), 64'd1);
            chk("t1_vld1", 64'(vq[vb+1]), 64'd2);
            chk("t1_vld2", 64'(vq[vb+2]), 64'd4);
        end
        chk("t1_smpl", 64'(smpl), 64'h0_FFF3_C1A5C);
        repeat (300) @(negedge clk);
        chk("t1_ndone", 64'(done_cnt - db), 64'd1);
        chk("t1_noextra", 64'(fq.size() - fb), 64'd6);

        // single middle channel
        fb = fq.size(); vb = vq.size();
        ch_en = 3'b010;
        pulse_start();
        wait_done(1500, "t2_to");
        @(negedge clk);
        chk("t2_frames", 64'(fq.size() - fb), 64'd2);
        if (fq.size() >= fb + 2) begin
            chk("t2_cmd0", 64'(fq[fb]), 64'h2000);
            chk("t2_cmd1", 64'(fq[fb+1]), 64'h2000);
        end
        chk("t2_nvld", 64'(vq.size() - vb), 64'd1);
        if (vq.size() > vb) chk("t2_vld", 64'(vq[vb]), 64'd2);

        // empty mask: done two cycles after start, no SPI activity
        fb = fq.size(); vb = vq.size(); sb = ss_low;
        ch_en = 3'b000;
        pulse_start();
        chk("t3_done_n1", 64'(sweep_done), 64'd0);
        @(negedge clk);
        chk("t3_done_n2", 64'(sweep_done), 64'd1);
        chk("t3_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t3_done_n3", 64'(sweep_done), 64'd0);
        repeat (20) @(negedge clk);
        chk("t3_ss", 64'(ss_low - sb), 64'd0);
        chk("t3_frames", 64'(fq.size() - fb), 64'd0);
        chk("t3_nvld", 64'(vq.size() - vb), 64'd0);

        // continuous mode: 16-cycle gap, start during gap ignored
        fb = fq.size(); db = done_cnt;
        ch_en = 3'b001;
        cont_en = 1'b1;
        wait_done(1500, "t4_to1");
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy) break;
            cnt++;
            start = (cnt == 5);
            @(negedge clk);
        end
        start = 1'b0;
        chk("t4_gap", 64'(cnt), 64'd16);
        repeat (50) @(negedge clk);
        cont_en = 1'b0;
        wait_done(1500, "t4_to2");
        @(negedge clk);
        chk("t4_busy", 64'(busy), 64'd0);
        repeat (60) @(negedge clk);
        chk("t4_norestart", 64'(busy), 64'd0);
        chk("t4_ndone", 64'(done_cnt - db), 64'd2);
        chk("t4_frames", 64'(fq.size() - fb), 64'd4);

        // reset in the middle of the read frame
        fb = fq.size();
        ch_en = 3'b111;
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (fq.size() > fb && SS_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_to", 64'(ok), 64'd1);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_smpl", 64'(smpl), 64'd0);
        chk("t5_vld", 64'(vld), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_ss", 64'(SS_n), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        fb = fq.size();
        pulse_start();
        wait_done(3000, "t5_to2");
        @(negedge clk);
        chk("t5_frames", 64'(fq.size() - fb), 64'd6);
        chk("t5_smpl2", 64'(smpl), 64'h0_FFF3_C1A5C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
